// File: rtl/wishbone_master.sv
// rtl/wishbone_master.sv - Wishbone classic single-transfer bus master for the CPU data path
//
// Accepts one load/store request at a time in IDLE and runs a single
// Wishbone read or write cycle, terminated by ACK_I or ERR_I. Completion is
// reported with a one-cycle O_valid pulse, with O_err alongside it on error.
// Every output is registered, so there is no combinational path from
// ACK_I/ERR_I/DAT_I to any output.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a bus cycle as an
// error after TIMEOUT_CYCLES BUS cycles without ACK_I/ERR_I.
//
// Ports:
//   I_clk, I_reset   clock, synchronous active-high reset
//   I_req            request strobe (sampled only in IDLE)
//   I_memrw          1 = write, 0 = read
//   I_address        byte address
//   I_data, I_sel    write data, byte enables
//   O_data           read data, held until the next completed read
//   O_valid, O_err   one-cycle completion / error pulses
//   O_busy           high from acceptance until the cycle before O_valid
//   CYC_O, STB_O     Wishbone cycle / strobe
//   WE_O, ADR_O      Wishbone write enable / address
//   DAT_O, SEL_O     Wishbone write data / byte select
//   DAT_I            Wishbone read data
//   ACK_I, ERR_I     Wishbone slave terminations

module wishbone_master #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      I_clk,
  input  logic                      I_reset,
  input  logic                      I_req,
  input  logic                      I_memrw,
  input  logic [ADDRESS_WIDTH-1:0]  I_address,
  input  logic [DATA_WIDTH-1:0]     I_data,
  input  logic [DATA_WIDTH/8-1:0]   I_sel,
  output logic [DATA_WIDTH-1:0]     O_data,
  output logic                      O_valid,
  output logic                      O_err,
  output logic                      O_busy,
  output logic                      CYC_O,
  output logic                      STB_O,
  output logic                      WE_O,
  output logic [ADDRESS_WIDTH-1:0]  ADR_O,
  output logic [DATA_WIDTH-1:0]     DAT_O,
  output logic [DATA_WIDTH/8-1:0]   SEL_O,
  input  logic [DATA_WIDTH-1:0]     DAT_I,
  input  logic                      ACK_I,
  input  logic                      ERR_I
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state;
  logic       tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // The counter holds the number of completed unterminated BUS cycles, so
  // the edge ending BUS cycle number TIMEOUT_CYCLES is the one that aborts.
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  // No watchdog in this build: BUS waits for the slave indefinitely. The
  // parameter is still referenced so both builds share one interface.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state   <= S_IDLE;
      CYC_O   <= 1'b0;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      ADR_O   <= '0;
      DAT_O   <= '0;
      SEL_O   <= '0;
      O_data  <= '0;
      O_valid <= 1'b0;
      O_err   <= 1'b0;
      O_busy  <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          O_valid <= 1'b0;
          O_err   <= 1'b0;
          if (I_req) begin
            WE_O   <= I_memrw;
            ADR_O  <= I_address;
            DAT_O  <= I_data;
            SEL_O  <= I_sel;
            CYC_O  <= 1'b1;
            STB_O  <= 1'b1;
            O_busy <= 1'b1;
            state  <= S_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        S_BUS: begin
          // ERR_I outranks ACK_I; a real termination outranks the watchdog.
          if (ERR_I || ACK_I || tmo_hit) begin
            CYC_O   <= 1'b0;
            STB_O   <= 1'b0;
            O_busy  <= 1'b0;
            O_valid <= 1'b1;
            O_err   <= ERR_I || !ACK_I;
            if (ACK_I && !ERR_I && !WE_O) begin
              O_data <= DAT_I;
            end
            state <= S_RESP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          O_valid <= 1'b0;
          O_err   <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// tb/tb_wishbone_master.sv - scoreboard bench for wishbone_master

module tb_wishbone_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        I_reset, I_req, I_memrw;
  logic [31:0] I_address, I_data;
  logic [3:0]  I_sel;
  logic [31:0] O_data;
  logic        O_valid, O_err, O_busy;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I;
  logic        ACK_I, ERR_I;

  wishbone_master #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .I_clk(clk), .I_reset(I_reset), .I_req(I_req), .I_memrw(I_memrw),
    .I_address(I_address), .I_data(I_data), .I_sel(I_sel),
    .O_data(O_data), .O_valid(O_valid), .O_err(O_err), .O_busy(O_busy),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
    .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; a negedge sample after edge E sees E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_data;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the next expected response.
  always @(negedge clk) begin
    if (O_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(O_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_time", 64'(cyc), 64'(e.at));
        check("rsp_data", 64'(O_data), 64'(e.data));
        check("rsp_err", 64'(O_err), 64'(e.err));
      end
    end
  end

  // One transfer from IDLE. kind: 0 = ACK, 1 = ERR, 2 = ACK and ERR together.
  // w = wait states before the termination is presented.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int w, input int kind,
                      input logic [31:0] rdata);
    exp_t e;
    int   n;
    I_req = 1'b1; I_memrw = we; I_address = adr; I_data = dat; I_sel = sel;
    ACK_I = 1'b0; ERR_I = 1'b0;
    n = cyc + 1;
    if (kind == 0 && !we) model_data = rdata;
    e.at = n + 1 + w; e.data = model_data; e.err = (kind != 0);
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    I_req = 1'b0; I_address = $urandom; I_data = $urandom; I_sel = 4'($urandom);
    for (int i = 0; i <= w; i++) begin
      check("bus_ctl", {61'd0, CYC_O, STB_O, WE_O}, {61'd0, 2'b11, we});
      check("bus_adr", 64'(ADR_O), 64'(adr));
      check("bus_dat", 64'(DAT_O), 64'(dat));
      check("bus_sel", 64'(SEL_O), 64'(sel));
      check("bus_busy", 64'(O_busy), 64'd1);
      DAT_I = (i == w) ? rdata : $urandom;
      if (i == w) begin
        ACK_I = (kind != 1);
        ERR_I = (kind != 0);
      end
      @(posedge clk); @(negedge clk);
    end
    // Response cycle: bus released; stray terminations must be ignored.
    check("resp_ctl", {62'd0, CYC_O, STB_O}, 64'd0);
    check("resp_busy", 64'(O_busy), 64'd0);
    ACK_I = 1'($urandom); ERR_I = 1'($urandom); DAT_I = $urandom;
    @(posedge clk); @(negedge clk);
    ACK_I = 1'b0; ERR_I = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] k;
    I_reset = 1'b1; I_req = 1'b0; I_memrw = 1'b0; I_address = '0; I_data = '0;
    I_sel = '0; DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
    model_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {58'd0, CYC_O, STB_O, WE_O, O_valid, O_err, O_busy}, 64'd0);
    check("rst_bus", {ADR_O, DAT_O}, 64'd0);
    check("rst_sel_data", {28'd0, SEL_O, O_data}, 64'd0);
    I_reset = 1'b0;
    @(posedge clk); @(negedge clk);

    // Directed cases.
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 3, 0, 32'h5555_AAAA);
    xfer(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 2, 32'h0BAD_F00D);
    xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 1, 32'hCAFE_0001);

    // Request held high: one bus cycle per IDLE acceptance, period 3.
    k = 32'hA5A5_0F0F;
    I_req = 1'b1; I_memrw = 1'b0; I_address = 32'h100; I_sel = 4'hF;
    ACK_I = 1'b1; DAT_I = k;
    n = cyc + 1;
    model_data = k;
    for (int t = 0; t < 3; t++) begin
      exp_t e;
      e.at = n + 1 + 3 * t; e.data = k; e.err = 1'b0;
      sb.push_back(e);
    end
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); @(negedge clk);
      check("hold_cyc", 64'(CYC_O), 64'(t % 3 == 0));
      if (t == 8) I_req = 1'b0;
    end
    ACK_I = 1'b0;
    @(posedge clk); @(negedge clk);

    // Randomized transfers.
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    // Reset in the second BUS cycle: bus released, no completion.
    I_req = 1'b1; I_memrw = 1'b0; I_address = 32'h200; I_sel = 4'hF;
    @(posedge clk); @(negedge clk);
    I_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_cyc", 64'(CYC_O), 64'd1);
    I_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rst_ctl", {58'd0, CYC_O, STB_O, WE_O, O_valid, O_err, O_busy}, 64'd0);
    check("mid_rst_bus", {ADR_O, DAT_O}, 64'd0);
    check("mid_rst_data", {28'd0, SEL_O, O_data}, 64'd0);
    model_data = '0;
    I_reset = 1'b0;
    @(posedge clk); @(negedge clk);

    // Silent slave.
    I_req = 1'b1; I_memrw = 1'b0; I_address = 32'h300; I_sel = 4'hF;
    n = cyc + 1;
`ifdef WB_MASTER_TIMEOUT_EN
    begin
      exp_t e;
      e.at = n + TMO; e.data = model_data; e.err = 1'b1;
      sb.push_back(e);
    end
    for (int t = 0; t < TMO; t++) begin
      @(posedge clk); @(negedge clk);
      I_req = 1'b0;
      check("tmo_wait_cyc", 64'(CYC_O), 64'd1);
    end
    @(posedge clk); @(negedge clk);
    check("tmo_abort_cyc", {62'd0, CYC_O, STB_O}, 64'd0);
    @(posedge clk); @(negedge clk);
`else
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); @(negedge clk);
      I_req = 1'b0;
      check("no_tmo_cyc", 64'(CYC_O), 64'd1);
    end
    I_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    I_reset = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
